// File: rtl/axis_iter_div.sv
// Iterative radix-2 restoring divider behind a two-operand / one-result AXI-Stream interface.
// Result word is {quotient, remainder}; SIGNED selects two's-complement or unsigned divide.
// Optional macro AXIS_DIV_EARLY_OUT_EN: skip the iteration when the divisor is zero or the
// dividend magnitude is below the divisor magnitude (result is unchanged, latency drops to 2).
module axis_iter_div #(
   parameter int unsigned WIDTH  = 32,
   parameter bit          SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   output logic               m_axis_dout_tvalid,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

   state_t             state_q, state_d;
   logic               held_a_q, held_a_d, held_b_q, held_b_d;
   logic               rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d, div_q, div_d;
   logic               sign_q_q, sign_q_d, sign_r_q, sign_r_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tvalid_q, tvalid_d;
   logic [2*WIDTH-1:0] tdata_q, tdata_d;

   logic               fire_a, fire_b;
   logic               neg_a, neg_b, sq, sr;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     shifted, diff;
   logic [WIDTH-1:0]   quo_step, rem_step;

   // Apply the quotient/remainder sign correction to unsigned magnitudes.
   function automatic logic [2*WIDTH-1:0] fixup(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] r,
                                                input logic             neg_q,
                                                input logic             neg_r);
      logic [WIDTH-1:0] qo, ro;
      qo = neg_q ? (WIDTH'(0) - q) : q;
      ro = neg_r ? (WIDTH'(0) - r) : r;
      return {qo, ro};
   endfunction

   // Operand handshakes, magnitudes and one restoring-division step.
   always_comb begin
      fire_a   = s_axis_dividend_tvalid & rdy_a_q;
      fire_b   = s_axis_divisor_tvalid & rdy_b_q;
      neg_a    = SIGNED & a_q[WIDTH-1];
      neg_b    = SIGNED & b_q[WIDTH-1];
      mag_a    = neg_a ? (WIDTH'(0) - a_q) : a_q;
      mag_b    = neg_b ? (WIDTH'(0) - b_q) : b_q;
      sq       = neg_a ^ neg_b;
      sr       = neg_a;
      // Remainder is always below the divisor, so the difference fits WIDTH+1 signed bits.
      shifted  = {rem_q, quo_q[WIDTH-1]};
      diff     = shifted - {1'b0, div_q};
      quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      held_a_d = held_a_q;
      held_b_d = held_b_q;
      a_d      = a_q;
      b_d      = b_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      div_d    = div_q;
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;
      cnt_d    = cnt_q;
      tvalid_d = 1'b0;
      tdata_d  = tdata_q;
      case (state_q)
         IDLE: begin
            if (fire_a) begin
               a_d      = s_axis_dividend_tdata;
               held_a_d = 1'b1;
            end
            if (fire_b) begin
               b_d      = s_axis_divisor_tdata;
               held_b_d = 1'b1;
            end
            if (held_a_d && held_b_d) state_d = LOAD;
         end
         LOAD: begin
            quo_d    = mag_a;
            div_d    = mag_b;
            rem_d    = '0;
            cnt_d    = '0;
            sign_q_d = sq;
            sign_r_d = sr;
            state_d  = CALC;
`ifdef AXIS_DIV_EARLY_OUT_EN
            if ((mag_b == '0) || (mag_a < mag_b)) begin
               state_d  = DONE;
               tvalid_d = 1'b1;
               tdata_d  = fixup((mag_b == '0) ? '1 : '0, mag_a, sq, sr);
            end
`endif
         end
         CALC: begin
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = DONE;
               tvalid_d = 1'b1;
               tdata_d  = fixup(quo_step, rem_step, sign_q_q, sign_r_q);
            end
         end
         DONE: begin
            state_d  = IDLE;
            held_a_d = 1'b0;
            held_b_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      rdy_a_d = (state_d == IDLE) & ~held_a_d;
      rdy_b_d = (state_d == IDLE) & ~held_b_d;
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         held_a_q <= 1'b0;
         held_b_q <= 1'b0;
         rdy_a_q  <= 1'b1;
         rdy_b_q  <= 1'b1;
         a_q      <= '0;
         b_q      <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
         cnt_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         held_a_q <= held_a_d;
         held_b_q <= held_b_d;
         rdy_a_q  <= rdy_a_d;
         rdy_b_q  <= rdy_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
         cnt_q    <= cnt_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
      end
   end

   assign s_axis_dividend_tready = rdy_a_q;
   assign s_axis_divisor_tready  = rdy_b_q;
   assign m_axis_dout_tvalid     = tvalid_q;
   assign m_axis_dout_tdata      = tdata_q;

endmodule

// File: tb/tb_axis_iter_div.sv
// Directed bench for axis_iter_div: a signed and an unsigned instance share one stimulus stream.
module tb_axis_iter_div;

   localparam int unsigned W = 32;
`ifdef AXIS_DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic           clk, reset;
   logic           dvd_valid, dvs_valid;
   logic [W-1:0]   dvd_data, dvs_data;
   logic           s_dvd_rdy, s_dvs_rdy, s_vld;
   logic           u_dvd_rdy, u_dvs_rdy, u_vld;
   logic [2*W-1:0] s_data, u_data;

   int             vectors = 0;
   int             miscompares = 0;
   int             s_first, u_first, s_cnt, u_cnt;
   logic [2*W-1:0] s_dat, u_dat;

   axis_iter_div #(.WIDTH(W), .SIGNED(1'b1)) u_sdiv (
      .clk(clk), .reset(reset),
      .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(s_dvd_rdy),
      .s_axis_dividend_tdata(dvd_data),
      .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(s_dvs_rdy),
      .s_axis_divisor_tdata(dvs_data),
      .m_axis_dout_tvalid(s_vld), .m_axis_dout_tdata(s_data));

   axis_iter_div #(.WIDTH(W), .SIGNED(1'b0)) u_udiv (
      .clk(clk), .reset(reset),
      .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(u_dvd_rdy),
      .s_axis_dividend_tdata(dvd_data),
      .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(u_dvs_rdy),
      .s_axis_divisor_tdata(dvs_data),
      .m_axis_dout_tvalid(u_vld), .m_axis_dout_tdata(u_data));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected latency: 2 when the early-out build short-cuts this divide, else 34.
   function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
      logic [W-1:0] ma, mb;
      ma = (sgn && a[W-1]) ? (W'(0) - a) : a;
      mb = (sgn && b[W-1]) ? (W'(0) - b) : b;
      return (EARLY && ((mb == '0) || (ma < mb))) ? 2 : 34;
   endfunction

   task automatic clear_mon();
      s_first = -1; u_first = -1; s_cnt = 0; u_cnt = 0; s_dat = '0; u_dat = '0;
   endtask

   // Sample both result ports on the falling edge of cycles k0..k1.
   task automatic collect(input int k0, input int k1);
      for (int k = k0; k <= k1; k++) begin
         @(negedge clk);
         if (s_vld) begin
            if (s_cnt == 0) begin s_first = k; s_dat = s_data; end
            s_cnt++;
         end
         if (u_vld) begin
            if (u_cnt == 0) begin u_first = k; u_dat = u_data; end
            u_cnt++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic check_res(input string tag, input int lat_s, input int lat_u,
                            input logic [63:0] es, input logic [63:0] eu);
      chk($sformatf("%s_s_lat", tag), 64'(s_first), 64'(lat_s));
      chk($sformatf("%s_s_pulses", tag), 64'(s_cnt), 64'd1);
      chk($sformatf("%s_s_data", tag), s_dat, es);
      chk($sformatf("%s_s_hold", tag), s_data, es);
      chk($sformatf("%s_u_lat", tag), 64'(u_first), 64'(lat_u));
      chk($sformatf("%s_u_pulses", tag), 64'(u_cnt), 64'd1);
      chk($sformatf("%s_u_data", tag), u_dat, eu);
      chk($sformatf("%s_u_hold", tag), u_data, eu);
   endtask

   // Both operands in cycle 0; results watched over cycles 1..40.
   task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] es, input logic [63:0] eu);
      clear_mon();
      dvd_valid = 1'b1; dvd_data = a; dvs_valid = 1'b1; dvs_data = b;
      @(posedge clk); #1;
      dvd_valid = 1'b0; dvs_valid = 1'b0;
      collect(1, 40);
      check_res(tag, lat(a, b, 1'b1), lat(a, b, 1'b0), es, eu);
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1;
      dvd_valid = 1'b0; dvs_valid = 1'b0; dvd_data = '0; dvs_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_s_rdy", {s_dvd_rdy, s_dvs_rdy}, 2'b11);
      chk("rst_u_rdy", {u_dvd_rdy, u_dvs_rdy}, 2'b11);
      chk("rst_s_vld", s_vld, 1'b0);
      chk("rst_u_vld", u_vld, 1'b0);
      chk("rst_s_data", s_data, 64'h0);
      chk("rst_u_data", u_data, 64'h0);
      @(posedge clk); #1;

      run_div("100_7", 32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002);
      run_div("m7_2", 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001);
      run_div("7_m2", 32'd7, 32'hFFFFFFFE, 64'hFFFFFFFD_00000001, 64'h00000000_00000007);
      run_div("m1_2", 32'hFFFFFFFF, 32'd2, 64'h00000000_FFFFFFFF, 64'h7FFFFFFF_00000001);
      run_div("min_m1", 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 64'h00000000_80000000);
      run_div("m100_7", 32'hFFFFFF9C, 32'd7, 64'hFFFFFFF2_FFFFFFFE, 64'h24924916_00000002);
      run_div("5_0", 32'd5, 32'd0, 64'hFFFFFFFF_00000005, 64'hFFFFFFFF_00000005);

      // Staggered operands: dividend cycle 0, stray dividend cycle 2, divisor cycle 5
      clear_mon();
      dvd_valid = 1'b1; dvd_data = 32'd50;
      @(negedge clk);
      chk("stag_c0_dvd_rdy", s_dvd_rdy, 1'b1);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         dvd_valid = (c == 2);
         dvd_data  = (c == 2) ? 32'd999 : 32'd50;
         dvs_valid = (c == 5);
         dvs_data  = 32'd5;
         @(negedge clk);
         chk($sformatf("stag_c%0d_s_dvd_rdy", c), s_dvd_rdy, 1'b0);
         chk($sformatf("stag_c%0d_u_dvd_rdy", c), u_dvd_rdy, 1'b0);
         chk($sformatf("stag_c%0d_s_dvs_rdy", c), s_dvs_rdy, 1'b1);
      end
      @(posedge clk); #1;
      dvd_valid = 1'b0; dvs_valid = 1'b0;
      @(negedge clk);
      chk("stag_c6_dvs_rdy", {s_dvs_rdy, u_dvs_rdy}, 2'b00);
      @(posedge clk); #1;
      collect(7, 45);
      check_res("stag", lat(32'd50, 32'd5, 1'b1) + 5, lat(32'd50, 32'd5, 1'b0) + 5,
                64'h0000000A_00000000, 64'h0000000A_00000000);

      // Reset during the 10th CALC cycle of 100/7 (cycle 11)
      clear_mon();
      dvd_valid = 1'b1; dvd_data = 32'd100; dvs_valid = 1'b1; dvs_data = 32'd7;
      @(posedge clk); #1;
      dvd_valid = 1'b0; dvs_valid = 1'b0;
      collect(1, 10);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_s_rdy", {s_dvd_rdy, s_dvs_rdy}, 2'b11);
      chk("abort_u_rdy", {u_dvd_rdy, u_dvs_rdy}, 2'b11);
      chk("abort_s_data", s_data, 64'h0);
      @(posedge clk); #1;
      collect(13, 50);
      chk("abort_s_no_vld", 64'(s_cnt), 64'd0);
      chk("abort_u_no_vld", 64'(u_cnt), 64'd0);
      run_div("9_3", 32'd9, 32'd3, 64'h00000003_00000000, 64'h00000003_00000000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed still running expected finished");
      $fatal(1, "timeout");
   end

endmodule
